// File: rtl/float_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: responder on the nd/rfd/rdy handshake,
// one operation in flight, fixed 26-cycle latency from capture to rdy.
module float_mul_seq #(
  parameter int FRAC_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [EXP_W+FRAC_W:0]    a,
  input  logic [EXP_W+FRAC_W:0]    b,
  input  logic                     operation_nd,
  output logic                     operation_rfd,
  output logic [EXP_W+FRAC_W:0]    result,
  output logic                     rdy,
  output logic                     underflow,
  output logic                     overflow,
  output logic                     invalid_op,
  output logic [1:0]               o_dbg_state
);

  localparam int W    = EXP_W + FRAC_W + 1;
  localparam int MW   = FRAC_W + 1;
  localparam int PW   = 2 * MW;
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_MUL, S_ROUND} state_t;

  // Handshake: operands are taken on an edge where operation_nd=1 and operation_rfd=1;
  // rfd is low for the whole operation, and rdy is a one-cycle pulse with rfd high again.
  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b, r_result;
  logic            r_a_zero, r_a_inf, r_a_nan, r_b_zero, r_b_inf, r_b_nan;
  logic [XW-1:0]   r_exp;
  logic [PW-1:0]   r_mcand, r_acc;
  logic [MW-1:0]   r_mplier;
  logic [4:0]      r_cnt;
  logic            r_rdy, r_uf, r_of, r_inv;

  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [FRAC_W-1:0] w_fa, w_fb;
  logic              w_sign, w_norm, w_guard, w_sticky, w_rup;
  logic [PW-2:0]     w_prod;
  logic [FRAC_W-1:0] w_frac;
  logic [FRAC_W:0]   w_frac_r;
  logic [XW-1:0]     w_exp_f;
  logic [W-1:0]      w_res;
  logic              w_uf, w_of, w_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (operation_nd) w_next = S_UNPACK;
      S_UNPACK: w_next = S_MUL;
      S_MUL:    if (r_cnt == 5'(MW - 1)) w_next = S_ROUND;
      S_ROUND:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_ea   = r_a[W-2:FRAC_W];
  assign w_eb   = r_b[W-2:FRAC_W];
  assign w_fa   = r_a[FRAC_W-1:0];
  assign w_fb   = r_b[FRAC_W-1:0];
  assign w_sign = r_a[W-1] ^ r_b[W-1];

  // Normalise so the leading one sits at bit PW-1, then round to nearest even.
  assign w_norm   = r_acc[PW-1];
  assign w_prod   = w_norm ? r_acc[PW-2:0] : {r_acc[PW-3:0], 1'b0};
  assign w_frac   = w_prod[PW-2 -: FRAC_W];
  assign w_guard  = w_prod[PW-2-FRAC_W];
  assign w_sticky = |w_prod[PW-3-FRAC_W:0];
  assign w_rup    = w_guard & (w_sticky | w_frac[0]);
  assign w_frac_r = {1'b0, w_frac} + (FRAC_W+1)'(w_rup);
  assign w_exp_f  = r_exp + XW'(w_norm) + XW'(w_frac_r[FRAC_W]);

  always_comb begin
    w_res = {w_sign, w_exp_f[EXP_W-1:0], w_frac_r[FRAC_W-1:0]};
    w_uf  = 1'b0;
    w_of  = 1'b0;
    w_inv = 1'b0;
    if (r_a_nan || r_b_nan || (r_a_zero && r_b_inf) || (r_b_zero && r_a_inf)) begin
      w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      w_inv = 1'b1;
    end else if (r_a_inf || r_b_inf) begin
      w_res = {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (r_a_zero || r_b_zero) begin
      w_res = {w_sign, {(W-1){1'b0}}};
    end else if ($signed(w_exp_f) >= $signed(XW'(EMAX))) begin
      w_res = {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_of  = 1'b1;
    end else if (w_exp_f[XW-1] || (w_exp_f == '0)) begin
      w_res = {w_sign, {(W-1){1'b0}}};
      w_uf  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0; r_b <= '0; r_result <= '0;
      r_a_zero <= 1'b0; r_a_inf <= 1'b0; r_a_nan <= 1'b0;
      r_b_zero <= 1'b0; r_b_inf <= 1'b0; r_b_nan <= 1'b0;
      r_exp <= '0; r_mcand <= '0; r_mplier <= '0; r_acc <= '0; r_cnt <= '0;
      r_rdy <= 1'b0; r_uf <= 1'b0; r_of <= 1'b0; r_inv <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      r_uf  <= 1'b0;
      r_of  <= 1'b0;
      r_inv <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (operation_nd) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_UNPACK: begin
          // Exponent field zero covers both true zero and denormals (flushed).
          r_a_zero <= (w_ea == '0);
          r_a_inf  <= (w_ea == '1) && (w_fa == '0);
          r_a_nan  <= (w_ea == '1) && (w_fa != '0);
          r_b_zero <= (w_eb == '0);
          r_b_inf  <= (w_eb == '1) && (w_fb == '0);
          r_b_nan  <= (w_eb == '1) && (w_fb != '0);
          r_exp    <= {2'b00, w_ea} + {2'b00, w_eb} - XW'(BIAS);
          r_mcand  <= (w_ea == '0) ? '0 : {{MW{1'b0}}, 1'b1, w_fa};
          r_mplier <= (w_eb == '0) ? '0 : {1'b1, w_fb};
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        S_MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= (r_cnt == 5'(MW - 1)) ? 5'd0 : r_cnt + 5'd1;
        end
        S_ROUND: begin
          r_result <= w_res;
          r_uf     <= w_uf;
          r_of     <= w_of;
          r_inv    <= w_inv;
          r_rdy    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign operation_rfd = (r_state == S_IDLE);
  assign result        = r_result;
  assign rdy           = r_rdy;
  assign underflow     = r_uf;
  assign overflow      = r_of;
  assign invalid_op    = r_inv;
  assign o_dbg_state   = r_state;

endmodule
